// File: rtl/qdrc_arb.sv
// Two-port round-robin arbiter in front of the QDR controller user interface.
// Issued reads are tagged in an in-order FIFO so returning data reaches its requester.
module qdrc_arb #(
    parameter int DATA_WIDTH   = 18,
    parameter int BW_WIDTH     = 2,
    parameter int ADDR_WIDTH   = 21,
    parameter int BURST_LENGTH = 4,
    parameter int TAG_DEPTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    p0_req,
    input  logic                    p0_rnw,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [2*DATA_WIDTH-1:0] p0_wr_data,
    input  logic [2*BW_WIDTH-1:0]   p0_wr_be,
    output logic                    p0_ack,
    output logic [2*DATA_WIDTH-1:0] p0_rd_data,
    output logic                    p0_rd_dvld,
    input  logic                    p1_req,
    input  logic                    p1_rnw,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [2*DATA_WIDTH-1:0] p1_wr_data,
    input  logic [2*BW_WIDTH-1:0]   p1_wr_be,
    output logic                    p1_ack,
    output logic [2*DATA_WIDTH-1:0] p1_rd_data,
    output logic                    p1_rd_dvld,
    input  logic                    phy_rdy,
    output logic                    usr_rd_strb,
    output logic                    usr_wr_strb,
    output logic [ADDR_WIDTH-1:0]   usr_addr,
    output logic [2*DATA_WIDTH-1:0] usr_wr_data,
    output logic [2*BW_WIDTH-1:0]   usr_wr_be,
    input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
    input  logic                    usr_rd_dvld,
    output logic                    rd_orphan
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] SPACING = 2'(BURST_LENGTH / 2 - 1);

    // Async assert, clk-synchronous release of the internal reset.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic                    ack0_q, ack0_d, ack1_q, ack1_d;
    logic                    rd_strb_q, rd_strb_d, wr_strb_q, wr_strb_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2*BW_WIDTH-1:0]   be_q, be_d;
    logic                    dvld0_q, dvld0_d, dvld1_q, dvld1_d;
    logic                    orphan_q, orphan_d;
    logic                    last_q, last_d;
    logic [1:0]              spacing_q, spacing_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    tag_mem_q [TAG_DEPTH];

    logic fifo_full, can_issue, elig0, elig1, gnt0, gnt1, gnt_any, gnt_rnw;
    logic push, pop, head_tag;

    // Handshake: pN_req is held with stable fields until the one-cycle pN_ack;
    // the cycle carrying pN_ack is never eligible, so a held req cannot double-issue.
    assign fifo_full = (count_q == CNT_W'(TAG_DEPTH));
    assign can_issue = phy_rdy && (spacing_q == 2'd0);
    assign elig0     = p0_req && !ack0_q && can_issue && (!p0_rnw || !fifo_full);
    assign elig1     = p1_req && !ack1_q && can_issue && (!p1_rnw || !fifo_full);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (elig0 && elig1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    assign gnt_any  = gnt0 || gnt1;
    assign gnt_rnw  = gnt0 ? p0_rnw : p1_rnw;
    assign push     = gnt_any && gnt_rnw;
    assign pop      = usr_rd_dvld && (count_q != '0);
    assign head_tag = tag_mem_q[rd_ptr_q];

    always_comb begin
        ack0_d    = gnt0;
        ack1_d    = gnt1;
        rd_strb_d = push;
        wr_strb_d = gnt_any && !gnt_rnw;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        last_d    = last_q;
        if (gnt_any) begin
            addr_d  = gnt0 ? p0_addr    : p1_addr;
            wdata_d = gnt0 ? p0_wr_data : p1_wr_data;
            be_d    = gnt0 ? p0_wr_be   : p1_wr_be;
            last_d  = gnt1;
        end
        spacing_d = spacing_q;
        if (gnt_any)                spacing_d = SPACING;
        else if (spacing_q != 2'd0) spacing_d = spacing_q - 2'd1;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        dvld0_d  = pop && !head_tag;
        dvld1_d  = pop && head_tag;
        rdata_d  = pop ? usr_rd_data : rdata_q;
        orphan_d = orphan_q || (usr_rd_dvld && (count_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rd_strb_q <= 1'b0;
            wr_strb_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            last_q    <= 1'b1;
            spacing_q <= 2'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dvld0_q   <= 1'b0;
            dvld1_q   <= 1'b0;
            rdata_q   <= '0;
            orphan_q  <= 1'b0;
        end else begin
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rd_strb_q <= rd_strb_d;
            wr_strb_q <= wr_strb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            last_q    <= last_d;
            spacing_q <= spacing_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dvld0_q   <= dvld0_d;
            dvld1_q   <= dvld1_d;
            rdata_q   <= rdata_d;
            orphan_q  <= orphan_d;
        end
    end

    // Tag storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= gnt1;
    end

    assign p0_ack      = ack0_q;
    assign p1_ack      = ack1_q;
    assign usr_rd_strb = rd_strb_q;
    assign usr_wr_strb = wr_strb_q;
    assign usr_addr    = addr_q;
    assign usr_wr_data = wdata_q;
    assign usr_wr_be   = be_q;
    assign p0_rd_dvld  = dvld0_q;
    assign p1_rd_dvld  = dvld1_q;
    assign p0_rd_data  = rdata_q;
    assign p1_rd_data  = rdata_q;
    assign rd_orphan   = orphan_q;
endmodule

// File: tb/tb_qdrc_arb.sv
// Directed bench for qdrc_arb: write issue, round-robin contention, tag FIFO full,
// phy_rdy gating, orphan read data and reset while reads are outstanding.
module tb_qdrc_arb;
    localparam int DW = 18;
    localparam int BW = 2;
    localparam int AW = 21;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            p0_req, p0_rnw, p1_req, p1_rnw;
    logic [AW-1:0]   p0_addr, p1_addr;
    logic [2*DW-1:0] p0_wr_data, p1_wr_data;
    logic [2*BW-1:0] p0_wr_be, p1_wr_be;
    logic            p0_ack, p1_ack, p0_rd_dvld, p1_rd_dvld;
    logic [2*DW-1:0] p0_rd_data, p1_rd_data;
    logic            phy_rdy;
    logic            usr_rd_strb, usr_wr_strb;
    logic [AW-1:0]   usr_addr;
    logic [2*DW-1:0] usr_wr_data, usr_rd_data;
    logic [2*BW-1:0] usr_wr_be;
    logic            usr_rd_dvld;
    logic            rd_orphan;

    int tests_run = 0;
    int failed    = 0;

    qdrc_arb #(
        .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW),
        .BURST_LENGTH(4), .TAG_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_rnw(p0_rnw), .p0_addr(p0_addr),
        .p0_wr_data(p0_wr_data), .p0_wr_be(p0_wr_be), .p0_ack(p0_ack),
        .p0_rd_data(p0_rd_data), .p0_rd_dvld(p0_rd_dvld),
        .p1_req(p1_req), .p1_rnw(p1_rnw), .p1_addr(p1_addr),
        .p1_wr_data(p1_wr_data), .p1_wr_be(p1_wr_be), .p1_ack(p1_ack),
        .p1_rd_data(p1_rd_data), .p1_rd_dvld(p1_rd_dvld),
        .phy_rdy(phy_rdy),
        .usr_rd_strb(usr_rd_strb), .usr_wr_strb(usr_wr_strb),
        .usr_addr(usr_addr), .usr_wr_data(usr_wr_data), .usr_wr_be(usr_wr_be),
        .usr_rd_data(usr_rd_data), .usr_rd_dvld(usr_rd_dvld),
        .rd_orphan(rd_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_rnw = 0; p0_addr = '0; p0_wr_data = '0; p0_wr_be = '0;
        p1_req = 0; p1_rnw = 0; p1_addr = '0; p1_wr_data = '0; p1_wr_be = '0;
        usr_rd_data = '0; usr_rd_dvld = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        phy_rdy = 1;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        repeat (4) tick();
    endtask

    logic [3:0] grant_pat;

    initial begin
        // Reset state
        do_reset();
        check("rst_strb", {usr_rd_strb, usr_wr_strb, p0_ack, p1_ack}, 4'b0000);
        check("rst_addr", usr_addr, 0);
        check("rst_dvld_orphan", {p0_rd_dvld, p1_rd_dvld, rd_orphan}, 3'b000);

        // Single write from P0, req held through the ack cycle
        p0_req = 1; p0_rnw = 0; p0_addr = 21'h12345;
        p0_wr_data = 36'hA5A5A5A5A; p0_wr_be = 4'hF;
        tick();
        check("wr_strbs", {usr_wr_strb, usr_rd_strb}, 2'b10);
        check("wr_acks", {p0_ack, p1_ack}, 2'b10);
        check("wr_addr", usr_addr, 21'h12345);
        check("wr_data", usr_wr_data, 36'hA5A5A5A5A);
        check("wr_be", usr_wr_be, 4'hF);
        tick();
        check("wr_no_regrant", {usr_wr_strb, usr_rd_strb, p0_ack}, 3'b000);
        p0_req = 0;
        tick();
        check("wr_quiet", {usr_wr_strb, usr_rd_strb, p0_ack}, 3'b000);
        check("wr_addr_hold", usr_addr, 21'h12345);

        // Contention: both ports read continuously from reset, expected P0,P1,P0,P1
        do_reset();
        p0_req = 1; p0_rnw = 1; p0_addr = 21'h00A00;
        p1_req = 1; p1_rnw = 1; p1_addr = 21'h00B11;
        grant_pat = 4'b1010;  // bit i = port of grant i
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_rd_strb", usr_rd_strb, 1'b1);
            check("cont_acks", {p1_ack, p0_ack}, grant_pat[i] ? 2'b10 : 2'b01);
            check("cont_addr", usr_addr, grant_pat[i] ? 21'h00B11 : 21'h00A00);
            if (i == 3) begin
                p0_req = 0; p1_req = 0;
            end
            tick();
            check("cont_gap", {usr_rd_strb, usr_wr_strb, p0_ack, p1_ack}, 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            usr_rd_dvld = 1; usr_rd_data = 36'hC0DE0000 + 36'(i);
            check("ret_before", {p1_rd_dvld, p0_rd_dvld}, (i == 0) ? 2'b00 : (grant_pat[i-1] ? 2'b10 : 2'b01));
            tick();
            check("ret_dvld", {p1_rd_dvld, p0_rd_dvld}, grant_pat[i] ? 2'b10 : 2'b01);
            check("ret_data", p0_rd_data, 36'hC0DE0000 + 36'(i));
            check("ret_data_p1", p1_rd_data, 36'hC0DE0000 + 36'(i));
        end
        usr_rd_dvld = 0;
        tick();
        check("ret_done", {p1_rd_dvld, p0_rd_dvld, rd_orphan}, 3'b000);

        // FIFO full: P1 fills 4 tags, 5th read held, P0 write passes meanwhile
        do_reset();
        p1_req = 1; p1_rnw = 1; p1_addr = 21'h1F000;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("full_fill_ack", p1_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        tick();
        check("full_held", {p1_ack, usr_rd_strb}, 2'b00);
        p0_req = 1; p0_rnw = 0; p0_addr = 21'h00777; p0_wr_data = 36'h123456789; p0_wr_be = 4'h3;
        tick();
        check("full_wr_pass", {p0_ack, p1_ack, usr_wr_strb, usr_rd_strb}, 4'b1010);
        check("full_wr_addr", usr_addr, 21'h00777);
        p0_req = 0;
        tick();
        check("full_held2", {p1_ack, usr_rd_strb}, 2'b00);
        tick();
        check("full_held3", {p1_ack, usr_rd_strb}, 2'b00);
        usr_rd_dvld = 1; usr_rd_data = 36'hFEEDBEEF;
        tick();
        usr_rd_dvld = 0;
        check("full_pop_dvld", {p1_rd_dvld, p0_rd_dvld}, 2'b10);
        check("full_pop_noack", p1_ack, 1'b0);
        tick();
        check("full_5th_grant", {p1_ack, usr_rd_strb}, 2'b11);
        check("full_5th_addr", usr_addr, 21'h1F000);
        p1_req = 0;

        // phy_rdy low blocks grants; rising edge grants the next cycle
        do_reset();
        phy_rdy = 0;
        p0_req = 1; p0_rnw = 0; p0_addr = 21'h00055;
        p1_req = 1; p1_rnw = 0; p1_addr = 21'h00066;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("phy_block", {usr_rd_strb, usr_wr_strb, p0_ack, p1_ack}, 4'b0000);
        end
        phy_rdy = 1;
        tick();
        check("phy_grant", {usr_wr_strb, p0_ack, p1_ack}, 3'b110);
        check("phy_addr", usr_addr, 21'h00055);
        p0_req = 0; p1_req = 0;

        // Orphan read data with empty FIFO
        tick();
        tick();
        check("orph_pre", rd_orphan, 1'b0);
        usr_rd_dvld = 1; usr_rd_data = 36'h0BADBAD;
        tick();
        usr_rd_dvld = 0;
        check("orph_no_dvld", {p1_rd_dvld, p0_rd_dvld}, 2'b00);
        check("orph_set", rd_orphan, 1'b1);
        check("orph_data_dropped", p0_rd_data, 0);
        repeat (3) tick();
        check("orph_sticky", rd_orphan, 1'b1);
        do_reset();
        check("orph_cleared", rd_orphan, 1'b0);

        // Reset with 3 reads outstanding
        p0_req = 1; p0_rnw = 1; p0_addr = 21'h00321;
        for (int i = 0; i < 5; i++) tick();
        check("mid_last_grant", {p0_ack, usr_rd_strb}, 2'b11);
        reset_n = 0;
        #1;
        check("mid_rst_outs", {p0_ack, p1_ack, usr_rd_strb, usr_wr_strb, p0_rd_dvld, p1_rd_dvld, rd_orphan}, 7'b0);
        check("mid_rst_addr", usr_addr, 0);
        idle_inputs();
        tick();
        tick();
        reset_n = 1;
        repeat (4) tick();
        usr_rd_dvld = 1;
        tick();
        usr_rd_dvld = 0;
        check("mid_fifo_empty", {p1_rd_dvld, p0_rd_dvld, rd_orphan}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
